// File: rtl/npc_pipe_pkg.sv
// Shared types and constants for the NPC pipeline hazard controller.
package npc_pipe_pkg;

    localparam int unsigned NPC_NREG  = 32;
    localparam int unsigned NPC_CNT_W = 2;
    localparam int unsigned RIDX_W    = 5;

    localparam logic [RIDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } hc_state_e;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters with one increment and one decrement port per cycle.
module sb_counter_bank
    import npc_pipe_pkg::*;
#(
    parameter int unsigned NREG  = NPC_NREG,
    parameter int unsigned CNT_W = NPC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en,
    input  logic [RIDX_W-1:0] inc_idx,
    input  logic              dec_en,
    input  logic [RIDX_W-1:0] dec_idx,
    input  logic [RIDX_W-1:0] rs1_idx,
    input  logic [RIDX_W-1:0] rs2_idx,
    input  logic [RIDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0]  cnt_rs1,
    output logic [CNT_W-1:0]  cnt_rs2,
    output logic [CNT_W-1:0]  cnt_rd,
    output logic [NREG-1:0]   pending,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            // A matching inc and dec in the same cycle cancel out.
            if (inc_en && inc_idx == RIDX_W'(i) && !(dec_en && dec_idx == RIDX_W'(i))) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec_en && dec_idx == RIDX_W'(i) &&
                         !(inc_en && inc_idx == RIDX_W'(i))) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt_rs1   = cnt_q[rs1_idx];
    assign cnt_rs2   = cnt_q[rs2_idx];
    assign cnt_rd    = cnt_q[rd_idx];
    assign underflow = dec_en && (cnt_q[dec_idx] == '0);

    for (genvar g = 0; g < NREG; g++) begin : g_pending
        assign pending[g] = |cnt_q[g];
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard and issue sequencer for the ID -> IS -> WB pipeline: hazard stalls,
// redirect flush of ID and stale fetch, and ebreak halt.
module pipe_hazard_ctrl
    import npc_pipe_pkg::*;
#(
    parameter int unsigned NREG  = NPC_NREG,
    parameter int unsigned CNT_W = NPC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic              id_rs1_ren,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic              id_rs2_ren,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic              id_rf_wen,
    input  logic              is_ready,
    input  logic              is_redirect,
    input  logic              if_busy,
    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic              wb_rf_wen,
    input  logic              wb_ebreak,
    output logic              id_issue,
    output logic              id_stall,
    output logic              id_flush,
    output logic              if_drop,
    output logic              halted,
    output logic              sb_err,
    output logic [NREG-1:0]   pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hc_state_e state_q, state_d;
    logic      sb_err_q;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
    logic             inc_en, dec_en, underflow, hazard;

    sb_counter_bank #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (inc_en),
        .inc_idx   (id_rd),
        .dec_en    (dec_en),
        .dec_idx   (wb_rd),
        .rs1_idx   (id_rs1),
        .rs2_idx   (id_rs2),
        .rd_idx    (id_rd),
        .cnt_rs1   (cnt_rs1),
        .cnt_rs2   (cnt_rs2),
        .cnt_rd    (cnt_rd),
        .pending   (pending),
        .underflow (underflow)
    );

    // Counters are read pre-update: a WB retiring this cycle does not unblock ID until next cycle.
    assign hazard = (id_rs1_ren && id_rs1 != REG_X0 && cnt_rs1 != '0) ||
                    (id_rs2_ren && id_rs2 != REG_X0 && cnt_rs2 != '0) ||
                    (id_rf_wen  && id_rd  != REG_X0 && cnt_rd == CNT_MAX);

    assign id_issue = id_valid && is_ready && !hazard && !is_redirect && (state_q == RUN);
    assign id_stall = id_valid && !id_issue && !id_flush;
    assign inc_en   = id_issue && id_rf_wen && (id_rd != REG_X0);
    assign dec_en   = wb_valid && wb_rf_wen && (wb_rd != REG_X0);
    assign halted   = (state_q == HALT);
    assign sb_err   = sb_err_q;

    always_comb begin
        state_d  = state_q;
        id_flush = 1'b0;
        if_drop  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (is_redirect) begin
                    id_flush = 1'b1;
                    if (if_busy) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if_drop = if_busy;
                if (is_redirect) begin
                    id_flush = 1'b1;
                end else if (!if_busy) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (wb_valid && wb_ebreak) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            sb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sb_err_q <= sb_err_q | underflow;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl, plus a hand-written RAW latency sequence.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_ren, id_rs2_ren, id_rf_wen;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        is_ready, is_redirect, if_busy;
    logic        wb_valid, wb_rf_wen, wb_ebreak;
    logic        id_issue, id_stall, id_flush, if_drop, halted, sb_err;
    logic [31:0] pending;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NREG  (32),
        .CNT_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs1_ren  (id_rs1_ren),
        .id_rs2      (id_rs2),
        .id_rs2_ren  (id_rs2_ren),
        .id_rd       (id_rd),
        .id_rf_wen   (id_rf_wen),
        .is_ready    (is_ready),
        .is_redirect (is_redirect),
        .if_busy     (if_busy),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_rf_wen   (wb_rf_wen),
        .wb_ebreak   (wb_ebreak),
        .id_issue    (id_issue),
        .id_stall    (id_stall),
        .id_flush    (id_flush),
        .if_drop     (if_drop),
        .halted      (halted),
        .sb_err      (sb_err),
        .pending     (pending)
    );

    // idc = {valid, rs1_ren, rs2_ren, rf_wen}; ctl = {is_ready, is_redirect, if_busy}
    // wbc = {wb_valid, wb_rf_wen, wb_ebreak}; ef = {issue, stall, flush, drop, halted, sb_err}
    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  idc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  ctl;
        logic [2:0]  wbc;
        logic [4:0]  wb_rd;
        logic [5:0]  ef;
        logic [31:0] ep;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] b(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    task automatic add(input string name, input logic r, input logic [3:0] idc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [2:0] ctl, input logic [2:0] wbc, input logic [4:0] wrd,
                       input logic [5:0] ef, input logic [31:0] ep);
        vec_t v;
        v.name = name; v.rst = r; v.idc = idc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.ctl = ctl; v.wbc = wbc; v.wb_rd = wrd; v.ef = ef; v.ep = ep;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst;
        {id_valid, id_rs1_ren, id_rs2_ren, id_rf_wen} = v.idc;
        id_rs1 = v.rs1;
        id_rs2 = v.rs2;
        id_rd  = v.rd;
        {is_ready, is_redirect, if_busy} = v.ctl;
        {wb_valid, wb_rf_wen, wb_ebreak} = v.wbc;
        wb_rd = v.wb_rd;
    endtask

    task automatic check(input string name, input logic [5:0] ef, input logic [31:0] ep);
        logic [5:0] got;
        got = {id_issue, id_stall, id_flush, if_drop, halted, sb_err};
        n_vec++;
        if (got !== ef || pending !== ep) begin
            n_err++;
            $display("FAIL %s: got flags=%b pending=%h, expected flags=%b pending=%h",
                     name, got, pending, ef, ep);
        end
    endtask

    initial begin
        vec_t v;
        // RAW on x5
        add("reset_state",      0, 4'b0000, 0, 0, 0, 3'b000, 3'b000, 0, 6'b000000, 0);
        add("raw_issue_x5",     0, 4'b1001, 0, 0, 5, 3'b100, 3'b000, 0, 6'b100000, 0);
        add("raw_stall",        0, 4'b1101, 5, 0, 6, 3'b100, 3'b000, 0, 6'b010000, b(5));
        add("raw_stall_wb_x5",  0, 4'b1101, 5, 0, 6, 3'b100, 3'b110, 5, 6'b010000, b(5));
        add("raw_issue_after",  0, 4'b1101, 5, 0, 6, 3'b100, 3'b000, 0, 6'b100000, 0);
        add("raw_drain_x6",     0, 4'b0000, 0, 0, 0, 3'b000, 3'b110, 6, 6'b000000, b(6));
        // x0 is never tracked
        add("x0_write",         0, 4'b1001, 0, 0, 0, 3'b100, 3'b000, 0, 6'b100000, 0);
        add("x0_read",          0, 4'b1111, 0, 0, 0, 3'b100, 3'b000, 0, 6'b100000, 0);
        // simultaneous inc/dec on x7
        add("x7_issue",         0, 4'b1001, 0, 0, 7, 3'b100, 3'b000, 0, 6'b100000, 0);
        add("x7_inc_dec",       0, 4'b1001, 0, 0, 7, 3'b100, 3'b110, 7, 6'b100000, b(7));
        add("x7_still_pend",    0, 4'b0000, 0, 0, 0, 3'b000, 3'b110, 7, 6'b000000, b(7));
        add("x7_cleared",       0, 4'b0000, 0, 0, 0, 3'b000, 3'b000, 0, 6'b000000, 0);
        // WAW saturation on x9
        add("waw_issue1",       0, 4'b1001, 0, 0, 9, 3'b100, 3'b000, 0, 6'b100000, 0);
        add("waw_issue2",       0, 4'b1001, 0, 0, 9, 3'b100, 3'b000, 0, 6'b100000, b(9));
        add("waw_issue3",       0, 4'b1001, 0, 0, 9, 3'b100, 3'b000, 0, 6'b100000, b(9));
        add("waw_sat_stall",    0, 4'b1001, 0, 0, 9, 3'b100, 3'b000, 0, 6'b010000, b(9));
        add("waw_stall_wb",     0, 4'b1001, 0, 0, 9, 3'b100, 3'b110, 9, 6'b010000, b(9));
        add("waw_release",      0, 4'b1001, 0, 0, 9, 3'b100, 3'b000, 0, 6'b100000, b(9));
        add("waw_drain1",       0, 4'b0000, 0, 0, 0, 3'b000, 3'b110, 9, 6'b000000, b(9));
        add("waw_drain2",       0, 4'b0000, 0, 0, 0, 3'b000, 3'b110, 9, 6'b000000, b(9));
        add("waw_drain3",       0, 4'b0000, 0, 0, 0, 3'b000, 3'b110, 9, 6'b000000, b(9));
        // redirect with an outstanding fetch
        add("redir_flush",      0, 4'b1000, 0, 0, 1, 3'b111, 3'b000, 0, 6'b001000, 0);
        add("flush_drop1",      0, 4'b1000, 0, 0, 1, 3'b101, 3'b000, 0, 6'b010100, 0);
        add("flush_drop2",      0, 4'b1000, 0, 0, 1, 3'b101, 3'b000, 0, 6'b010100, 0);
        add("flush_drop3",      0, 4'b1000, 0, 0, 1, 3'b101, 3'b000, 0, 6'b010100, 0);
        add("flush_exit",       0, 4'b1000, 0, 0, 1, 3'b100, 3'b000, 0, 6'b010000, 0);
        add("flush_run_issue",  0, 4'b1000, 0, 0, 1, 3'b100, 3'b000, 0, 6'b100000, 0);
        add("redir_again",      0, 4'b1000, 0, 0, 1, 3'b111, 3'b000, 0, 6'b001000, 0);
        add("redir_in_flush",   0, 4'b1000, 0, 0, 1, 3'b111, 3'b000, 0, 6'b001100, 0);
        add("flush2_exit",      0, 4'b1000, 0, 0, 1, 3'b100, 3'b000, 0, 6'b010000, 0);
        // underflow
        add("underflow_x3",     0, 4'b0000, 0, 0, 0, 3'b000, 3'b110, 3, 6'b000000, 0);
        add("sb_err_set",       0, 4'b0000, 0, 0, 0, 3'b000, 3'b000, 0, 6'b000001, 0);
        // ebreak halt with writes in flight
        add("x4_issue",         0, 4'b1001, 0, 0, 4, 3'b100, 3'b000, 0, 6'b100001, 0);
        add("ebreak_x11",       0, 4'b1001, 0, 0, 11, 3'b100, 3'b101, 0, 6'b100001, b(4));
        add("halt_drain_x4",    0, 4'b1001, 0, 0, 11, 3'b100, 3'b110, 4, 6'b010011, b(4) | b(11));
        add("halt_drained",     0, 4'b1000, 0, 0, 0, 3'b100, 3'b000, 0, 6'b010011, b(11));
        add("halt_no_flush",    0, 4'b1000, 0, 0, 0, 3'b111, 3'b000, 0, 6'b010011, b(11));
        add("rst_in_halt",      1, 4'b0000, 0, 0, 0, 3'b000, 3'b000, 0, 6'b000011, b(11));
        add("after_rst",        0, 4'b0000, 0, 0, 0, 3'b000, 3'b000, 0, 6'b000000, 0);
        // reset while flushing
        add("redir_no_id",      0, 4'b0000, 0, 0, 0, 3'b011, 3'b000, 0, 6'b001000, 0);
        add("flush_no_id",      0, 4'b0000, 0, 0, 0, 3'b001, 3'b000, 0, 6'b000100, 0);
        add("rst_in_flush",     1, 4'b0000, 0, 0, 0, 3'b001, 3'b000, 0, 6'b000100, 0);
        add("run_after_rst",    0, 4'b0000, 0, 0, 0, 3'b001, 3'b000, 0, 6'b000000, 0);

        v.name = "init"; v.rst = 1'b1; v.idc = '0; v.rs1 = '0; v.rs2 = '0; v.rd = '0;
        v.ctl = '0; v.wbc = '0; v.wb_rd = '0; v.ef = '0; v.ep = '0;
        apply(v);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            check(tbl[i].name, tbl[i].ef, tbl[i].ep);
        end

        // RAW latency on x12: WB in the third stalled cycle, issue exactly one cycle later.
        @(negedge clk);
        v = tbl[0];
        v.idc = 4'b1001; v.rd = 5'd12; v.ctl = 3'b100;
        apply(v);
        #1;
        check("seq_issue_x12", 6'b100000, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            v.idc = 4'b1100; v.rs1 = 5'd12; v.rd = 5'd0;
            v.wbc = (k == 2) ? 3'b110 : 3'b000;
            v.wb_rd = 5'd12;
            apply(v);
            #1;
            if (k < 3) begin
                check($sformatf("seq_raw_stall_%0d", k), 6'b010000, b(12));
            end else begin
                check("seq_raw_issue", 6'b100000, 0);
            end
        end

        @(negedge clk);
        apply(tbl[0]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
